memory_interface: RTL
=====================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 SHALL provide parameter ADDR_W, default 9, address width from MAR.
REQ-002 SHALL provide parameter DATA_W, default 32, data word width.
REQ-003 SHALL provide parameter DEPTH, default 512, number of implemented words.
REQ-004 SHALL provide parameter WAIT_CYCLES, default 2, access latency in cycles; legal range 1..15.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port mar_q  input  ADDR_W  word address from the MAR.
REQ-008 SHALL have port mdr_q  input  DATA_W  write data from the MDR output.
REQ-009 SHALL have port read_req  input  1  request a memory read.
REQ-010 SHALL have port write_req  input  1  request a memory write.
REQ-011 SHALL have port Mdatain  output  DATA_W  registered read data feeding the MDR input mux.
REQ-012 SHALL have port mdr_read  output  1  MDR mux select, 1 = take Mdatain.
REQ-013 SHALL have port mdr_en  output  1  one-cycle MDR load enable.
REQ-014 SHALL have port busy  output  1  transaction in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port err  output  1  one-cycle out-of-range pulse.

Function
REQ-017 SHALL contain an internal DEPTH x DATA_W word array; contents not reset.
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on request, ACCESS->RESP when wait counter expires, RESP->IDLE unconditionally.
REQ-019 SHALL sample read_req/write_req only in IDLE; requests in ACCESS or RESP are ignored, not queued.
REQ-020 SHALL give read priority when read_req and write_req are both high in IDLE; the write is dropped.
REQ-021 SHALL latch mar_q, mdr_q and the operation type at the edge leaving IDLE; later input changes have no effect.
REQ-022 SHALL hold ACCESS for exactly WAIT_CYCLES cycles using a 4-bit down-counter loaded with WAIT_CYCLES-1.
REQ-023 SHALL perform the array write, or capture the array word into Mdatain, at the edge ending the last ACCESS cycle.
REQ-024 SHALL assert done for the single RESP cycle; with request in cycle 0, done is high in cycle WAIT_CYCLES+1 and a new request is accepted in cycle WAIT_CYCLES+2.
REQ-025 SHALL assert busy in all ACCESS and RESP cycles and deassert it in IDLE.
REQ-026 SHALL assert mdr_read and mdr_en together only in the RESP cycle of a successful read; both low otherwise, including for writes.
REQ-027 SHALL hold Mdatain unchanged except at a successful read capture.
REQ-028 SHALL return the newly written value for a read to the same address issued immediately after a write completes.

Reset
REQ-029 SHALL on clr high at a rising edge force state IDLE, counter 0, Mdatain 0, and busy, done, mdr_read, mdr_en, err all 0.
REQ-030 SHALL give clr priority over every transaction; an access whose final ACCESS edge coincides with clr SHALL not write the array or update Mdatain.

Configuration
REQ-031 SHALL compile range checking in only when macro MEM_RANGE_CHECK_EN is defined.
REQ-032 SHALL with MEM_RANGE_CHECK_EN, for latched address >= DEPTH, keep normal timing, suppress the array access, leave Mdatain unchanged, keep mdr_en/mdr_read low, and assert err with done in RESP.
REQ-033 SHALL without MEM_RANGE_CHECK_EN, size the array at 2**ADDR_W words (DEPTH ignored), tie err to 0, and treat every address as valid.

Verification (WAIT_CYCLES=2, DEPTH=512 unless stated)
REQ-034 SHALL cover: write_req, mar_q=0x005, mdr_q=0xDEADBEEF in cycle 0 -> busy cycles 1-3, done cycle 3, mdr_en 0.
REQ-035 SHALL cover: read_req, mar_q=0x005 in the cycle after that done -> Mdatain=0xDEADBEEF, mdr_read=mdr_en=done=1 for exactly one cycle, 3 cycles after the request.
REQ-036 SHALL cover: read_req and write_req both high, mar_q=0x005, mdr_q=0x12345678 -> read performed, Mdatain=0xDEADBEEF, array word unchanged.
REQ-037 SHALL cover: read_req pulsed again in cycles 1-3 of a transaction -> ignored, exactly one done pulse.
REQ-038 SHALL cover: clr high in cycle 2 of a write of 0x0000FFFF to 0x010 -> IDLE next cycle, all outputs 0, later read of 0x010 returns the prior contents.
REQ-039 SHALL cover: MEM_RANGE_CHECK_EN defined, DEPTH=256, read of 0x1F0 -> err=done=1 in cycle 3, mdr_en 0, Mdatain unchanged.

Source files
------------

// File: rtl/memory_interface.sv
// Word-addressed memory behind a MAR/MDR datapath with a fixed access latency.
// Optional build macro MEM_RANGE_CHECK_EN adds address range checking against DEPTH.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for read_req/write_req; request fields latched on exit
// ACCESS | wait counter running; array access on the edge ending the last cycle
// RESP   | one-cycle response: done, plus mdr_read/mdr_en or err
module memory_interface #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_q,
  input  logic [DATA_W-1:0] mdr_q,
  input  logic              read_req,
  input  logic              write_req,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mdr_read,
  output logic              mdr_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

`ifdef MEM_RANGE_CHECK_EN
  localparam int MEM_WORDS = DEPTH;
`else
  localparam int MEM_WORDS = 2 ** ADDR_W;
`endif
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              op_read;
  logic              addr_ok;
  logic              last_access;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [MEM_WORDS];

`ifdef MEM_RANGE_CHECK_EN
  assign addr_ok = (32'(addr_q) < 32'(DEPTH));
`else
  assign addr_ok = 1'b1;
`endif

  assign idx         = IDX_W'(addr_q);
  assign last_access = (state == S_ACCESS) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      Mdatain <= '0;
      op_read <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // read wins when both requests arrive together
          if (read_req || write_req) begin
            state   <= S_ACCESS;
            cnt     <= WAIT_LOAD;
            op_read <= read_req;
            addr_q  <= mar_q;
            data_q  <= mdr_q;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
            if (op_read && addr_ok) begin
              Mdatain <= mem[idx];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // array has no reset; clr still blocks a write landing on the same edge
  always_ff @(posedge clk) begin
    if (!clr && last_access && !op_read && addr_ok) begin
      mem[idx] <= data_q;
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_RESP);
  assign mdr_read = done && op_read && addr_ok;
  assign mdr_en   = done && op_read && addr_ok;

`ifdef MEM_RANGE_CHECK_EN
  assign err = done && !addr_ok;
`else
  assign err = 1'b0;
`endif

endmodule
